// File: rtl/joypad_ctrl_if.sv
// Peripheral bus interface shared by the memory-mapped blocks.
// The CPU side drives address, write data and strobes; the peripheral
// returns read data combinationally in the same cycle.
interface Bus_if;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic        write_en;
  logic        read_en;
  logic [7:0]  rdata;

  modport Peripheral_side (
    input  addr,
    input  wdata,
    input  write_en,
    input  read_en,
    output rdata
  );

  modport Host_side (
    output addr,
    output wdata,
    output write_en,
    output read_en,
    input  rdata
  );
endinterface

// File: rtl/joypad_ctrl.sv
// Game Boy joypad controller (JOYP register).
// Raw buttons pass through a two-flop synchroniser and a per-button
// debouncer; the debounced state is folded into the active-low P14/P15
// matrix nibble. A falling bit in that nibble raises a one-cycle IRQ.
// Optional feature: define JOYPAD_DEBUG_EN to add a force register at
// DEBUG_ADDR that ORs injected presses into the effective button state.
module joypad_ctrl #(
  parameter logic [15:0] JOYP_ADDR       = 16'hFF00,
  parameter int          DEBOUNCE_CYCLES = 4,
  parameter logic [15:0] DEBUG_ADDR      = 16'hFF7F
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [7:0]     buttons,
  Bus_if.Peripheral_side bus,
  output logic           irq_joypad
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [7:0]       sync1_q;
  logic [7:0]       sync_q;
  logic [7:0]       deb_q, deb_d;
  logic [CNT_W-1:0] cnt_q [8];
  logic [CNT_W-1:0] cnt_d [8];
  logic [1:0]       sel_q, sel_d;
  logic [3:0]       prev_n_q, prev_n_d;
  logic             irq_q, irq_d;
  logic [7:0]       eff;
  logic [3:0]       n;

`ifdef JOYPAD_DEBUG_EN
  logic [7:0]       force_q, force_d;

  // Debug force register: software-visible injected presses.
  always_comb begin
    force_d = force_q;
    if (bus.write_en && bus.addr == DEBUG_ADDR) force_d = bus.wdata;
  end

  // Force register storage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) force_q <= 8'h00;
    else       force_q <= force_d;
  end

  assign eff = deb_q | force_q;
`else
  // Only wdata[5:4] matter when the debug register is absent.
  logic unused_wdata;
  assign unused_wdata = ^{bus.wdata[7:6], bus.wdata[3:0]};
  assign eff = deb_q;
`endif

  // Two-flop synchroniser for the asynchronous button levels.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 8'h00;
      sync_q  <= 8'h00;
    end else begin
      // NOTE: non-blocking assignments let every flop sample the pre-edge
      // value, so the two stages really form a two-cycle pipeline.
      sync1_q <= buttons;
      sync_q  <= sync1_q;
    end
  end

  // Debounce: count consecutive disagreeing samples, accept on the last one.
  always_comb begin
    // NOTE: default every combinational output first so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    deb_d = deb_q;
    for (int i = 0; i < 8; i++) begin
      cnt_d[i] = '0;
      if (sync_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CNT_LAST) deb_d[i] = sync_q[i];
        else                      cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // Select bits are the only writable part of JOYP.
  always_comb begin
    sel_d = sel_q;
    if (bus.write_en && bus.addr == JOYP_ADDR) sel_d = bus.wdata[5:4];
  end

  // Active-low matrix nibble: a low select line exposes its button group.
  always_comb begin
    n = ~(({4{~sel_q[0]}} & eff[3:0]) | ({4{~sel_q[1]}} & eff[7:4]));
  end

  // Interrupt on any 1->0 transition of the nibble since the last cycle.
  always_comb begin
    prev_n_d = n;
    irq_d    = |(prev_n_q & ~n);
  end

  // State registers for debounce, select and interrupt tracking.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      deb_q    <= 8'h00;
      sel_q    <= 2'b11;
      prev_n_q <= 4'hF;
      irq_q    <= 1'b0;
      for (int i = 0; i < 8; i++) cnt_q[i] <= '0;
    end else begin
      deb_q    <= deb_d;
      sel_q    <= sel_d;
      prev_n_q <= prev_n_d;
      irq_q    <= irq_d;
      for (int i = 0; i < 8; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // Combinational read mux; unmapped addresses float high.
  always_comb begin
    bus.rdata = 8'hFF;
    if (bus.read_en && bus.addr == JOYP_ADDR) begin
      bus.rdata = {2'b11, sel_q, n};
    end
`ifdef JOYPAD_DEBUG_EN
    else if (bus.read_en && bus.addr == DEBUG_ADDR) begin
      bus.rdata = eff;
    end
`else
    else if (bus.read_en && bus.addr == DEBUG_ADDR) begin
      bus.rdata = 8'hFF;
    end
`endif
  end

  assign irq_joypad = irq_q;

endmodule

// File: tb/tb_joypad_ctrl.sv
// Self-checking bench for joypad_ctrl: directed scenarios with literal
// expectations, then randomized buttons, writes, reads and resets checked
// every cycle against a behavioural model.
module tb_joypad_ctrl;

  localparam logic [15:0] JOYP = 16'hFF00;
  localparam logic [15:0] DBG  = 16'hFF7F;
  localparam int          D    = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] buttons = 8'h00;
  logic       irq_joypad;

  Bus_if bus ();

  joypad_ctrl #(.JOYP_ADDR(JOYP), .DEBOUNCE_CYCLES(D), .DEBUG_ADDR(DBG)) dut (
    .clk        (clk),
    .reset      (reset),
    .buttons    (buttons),
    .bus        (bus),
    .irq_joypad (irq_joypad)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit [7:0] m_s1, m_s2;       // buttons delayed by one and two edges
  bit [7:0] m_deb;
  bit [7:0] m_force;
  bit [1:0] m_sel;
  bit [3:0] m_nlast;
  bit       m_irq;
  bit [7:0] m_win[$];         // last D synchronised samples

  // Row k reads low when any selected group has its button k pressed.
  function automatic logic [3:0] matrix(input logic [7:0] st, input logic [1:0] sl);
    logic [3:0] r;
    for (int k = 0; k < 4; k++) begin
      r[k] = !((!sl[0] && st[k]) || (!sl[1] && st[k+4]));
    end
    return r;
  endfunction

  always @(posedge clk or posedge reset) begin
    logic [3:0] n_cur;
    bit         all_diff;
    if (reset) begin
      m_s1 = 0; m_s2 = 0; m_deb = 0; m_force = 0;
      m_sel = 2'b11; m_nlast = 4'hF; m_irq = 0;
      m_win.delete();
    end else begin
      n_cur   = matrix(m_deb | m_force, m_sel);
      m_irq   = |(m_nlast & ~n_cur);
      m_nlast = n_cur;
      // A button changes once D consecutive samples all disagree with it.
      m_win.push_back(m_s2);
      if (m_win.size() > D) void'(m_win.pop_front());
      if (m_win.size() == D) begin
        for (int i = 0; i < 8; i++) begin
          all_diff = 1;
          foreach (m_win[k]) if (m_win[k][i] == m_deb[i]) all_diff = 0;
          if (all_diff) m_deb[i] = m_s2[i];
        end
      end
      m_s2 = m_s1;
      m_s1 = buttons;
      if (bus.write_en && bus.addr == JOYP) m_sel = bus.wdata[5:4];
`ifdef JOYPAD_DEBUG_EN
      if (bus.write_en && bus.addr == DBG) m_force = bus.wdata;
`endif
    end
  end

  function automatic logic [7:0] exp_rdata();
    if (bus.read_en && bus.addr == JOYP) return {2'b11, m_sel, matrix(m_deb | m_force, m_sel)};
`ifdef JOYPAD_DEBUG_EN
    if (bus.read_en && bus.addr == DBG) return m_deb | m_force;
`endif
    return 8'hFF;
  endfunction

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (!reset) begin
      check("model_rdata", bus.rdata, exp_rdata());
      check("model_irq", {7'b0, irq_joypad}, {7'b0, m_irq});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
    bus.addr     = a;
    bus.wdata    = d;
    bus.write_en = 1'b1;
    cyc();
    bus.write_en = 1'b0;
    bus.addr     = JOYP;
  endtask

  task automatic count_irq(input int n, output int pulses);
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      cyc();
      if (irq_joypad === 1'b1) pulses++;
    end
  endtask

  int p;
  int r;
  int bit_idx;

  initial begin
    bus.addr = JOYP; bus.wdata = 8'h00; bus.write_en = 1'b0; bus.read_en = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    check("reset_rdata", bus.rdata, 8'hFF);
    check("reset_irq", {7'b0, irq_joypad}, 8'h00);

    // D-pad select, Right held: visible exactly 2 + D edges later
    bus_write(JOYP, 8'h20);
    buttons = 8'h01;
    wait_cycles(1 + D);
    check("right_before_accept", bus.rdata, 8'hEF);
    cyc();
    check("right_after_accept", bus.rdata, 8'hEE);
    count_irq(6, p);
    check("right_irq_pulses", 8'(p), 8'd1);

    // Button select, A held, 2-cycle Right glitch
    buttons = 8'h00;
    wait_cycles(10);
    bus_write(JOYP, 8'h10);
    buttons = 8'h10;
    wait_cycles(2);
    buttons = 8'h11;
    wait_cycles(2);
    buttons = 8'h10;
    count_irq(12, p);
    check("a_irq_pulses", 8'(p), 8'd1);
    check("a_rdata", bus.rdata, 8'hDE);

    // Start held while deselected, then exposed by a select write
    buttons = 8'h00;
    wait_cycles(10);
    bus_write(JOYP, 8'h30);
    buttons = 8'h80;
    count_irq(10, p);
    check("start_hidden_irq", 8'(p), 8'd0);
    check("start_hidden_rdata", bus.rdata, 8'hFF);
    bus_write(JOYP, 8'h10);
    check("start_exposed_rdata", bus.rdata, 8'hD7);
    check("start_irq_same_cycle", {7'b0, irq_joypad}, 8'h00);
    cyc();
    check("start_irq_next_cycle", {7'b0, irq_joypad}, 8'h01);
    cyc();
    check("start_irq_one_cycle", {7'b0, irq_joypad}, 8'h00);
    bus_write(JOYP, 8'h30);
    check("deselect_rdata", bus.rdata, 8'hFF);
    count_irq(4, p);
    check("deselect_irq", 8'(p), 8'd0);

    // Reset mid-press while irq is high
    buttons = 8'h05;
    wait_cycles(10);
    bus_write(JOYP, 8'h00);
    check("both_sel_rdata", bus.rdata, 8'hCA);
    cyc();
    check("both_sel_irq", {7'b0, irq_joypad}, 8'h01);
    reset = 1'b1;
    #1;
    check("async_reset_irq", {7'b0, irq_joypad}, 8'h00);
    check("async_reset_rdata", bus.rdata, 8'hFF);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    count_irq(12, p);
    check("post_reset_irq", 8'(p), 8'd0);
    check("post_reset_rdata", bus.rdata, 8'hFF);
    bus_write(JOYP, 8'h00);
    check("reselect_rdata", bus.rdata, 8'hCA);
    count_irq(4, p);
    check("reselect_irq", 8'(p), 8'd1);

`ifdef JOYPAD_DEBUG_EN
    // Forced Down press bypasses the debounce delay
    buttons = 8'h00;
    wait_cycles(10);
    bus_write(JOYP, 8'h20);
    cyc();
    bus_write(DBG, 8'h08);
    check("force_rdata", bus.rdata, 8'hE7);
    cyc();
    check("force_irq", {7'b0, irq_joypad}, 8'h01);
    bus.addr = DBG;
    #1;
    check("force_readback", bus.rdata, 8'h08);
    bus.addr = JOYP;
    bus_write(DBG, 8'h00);
`endif

    // Randomized traffic checked by the per-cycle model comparison
    for (int c = 0; c < 4000; c++) begin
      r = $urandom_range(0, 99);
      if (r < 15) begin
        bit_idx = $urandom_range(0, 7);
        buttons[bit_idx] = ~buttons[bit_idx];
      end else if (r < 18) begin
        buttons = 8'($urandom);
      end
      r = $urandom_range(0, 9);
      bus.addr     = (r < 6) ? JOYP : (r < 8) ? DBG : 16'($urandom);
      bus.wdata    = 8'($urandom);
      bus.write_en = ($urandom_range(0, 9) == 0);
      bus.read_en  = ($urandom_range(0, 3) != 0);
      reset        = ($urandom_range(0, 599) == 0);
      cyc();
    end
    reset = 1'b0;
    bus.write_en = 1'b0;
    wait_cycles(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/joypad_ctrl.md
Name: joypad_ctrl

Overview:
- Game Boy joypad controller at JOYP (FF00) on the peripheral bus.
- Samples eight physical button inputs through a synchroniser and per-button debouncer.
- Presents the active-low P14/P15 matrix view in JOYP and raises a one-cycle joypad interrupt request on any falling edge of JOYP[3:0].
- Successor to the plain JOYP latch; adds real input handling, a matrix select, debounce and IRQ.

Parameters:
- JOYP_ADDR, 16'hFF00: bus address of the JOYP register.
- DEBOUNCE_CYCLES, 4: consecutive stable synchronised samples needed before a button state change is accepted. Legal range 1..255.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1): width of each debounce counter (derived, not overridden).
- DEBUG_ADDR, 16'hFF7F: address of the debug register. Used only with JOYPAD_DEBUG_EN.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- buttons  input  8  raw button levels, 1 = pressed, asynchronous to clk. Bit map: [0] Right, [1] Left, [2] Up, [3] Down, [4] A, [5] B, [6] Select, [7] Start.
- bus  Bus_if.Peripheral_side  -  addr, wdata, write_en, read_en in; rdata out
- irq_joypad  output  1  one-cycle pulse, joypad interrupt request (IF bit 4)

Behaviour:
- Reset is asynchronous and active-high; clock is clk. All state below is cleared by reset.
- Reset values:
  - select bits JOYP[5:4] = 2'b11
  - synchroniser flops = 0
  - debounced state deb[7:0] = 0 (all released)
  - debounce counters = 0
  - irq_joypad = 0
  - previous nibble prev_n = 4'hF
- Synchroniser: two flops per bit, so buttons reaches sync[7:0] with 2 cycles of latency.
- Debounce, per bit i:
  - If sync[i] == deb[i], clear cnt[i].
  - Otherwise increment cnt[i]. On the cycle cnt[i] reaches DEBOUNCE_CYCLES-1, set deb[i] <= sync[i] and cnt[i] <= 0.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes deb.
  - Latency from a stable input edge to deb is 2 + DEBOUNCE_CYCLES cycles.
  - The counter saturates logically by reset-to-0 on accept; it never wraps.
- Writes:
  - A write to JOYP_ADDR with write_en updates only JOYP[5:4] from wdata[5:4].
  - wdata bits 7:6 and 3:0 are ignored.
- Matrix nibble, active-low, combinational from deb and sel:
  - n = ~( ({4{~sel[0]}} & deb[3:0]) | ({4{~sel[1]}} & deb[7:4]) )
  - sel[0] = JOYP[4] (P14, d-pad); sel[1] = JOYP[5] (P15, buttons).
  - Both selected: OR of both groups. Neither selected: n = 4'hF.
- Read (combinational, same cycle):
  - rdata defaults to 8'hFF.
  - With read_en and addr == JOYP_ADDR: rdata = {2'b11, sel, n}.
- Interrupt:
  - Each cycle, prev_n <= n.
  - irq_joypad <= |(prev_n & ~n), i.e. registered, asserted the cycle after any JOYP[3:0] bit goes 1->0.
  - This applies equally to a button press and to a select write that exposes an already-held button.
  - Multiple bits falling in the same cycle produce a single pulse. Rising bits never pulse.
- Simultaneous events: a write to sel and a debounce accept in the same cycle both take effect; n and irq are evaluated from the new values on the next cycle.
- Reset mid-operation:
  - Counters and deb are cleared, so any pending debounce is discarded.
  - irq is deasserted immediately (asynchronous).
  - prev_n = 4'hF, so no spurious pulse occurs after reset release.

Optional Feature:
- Macro: JOYPAD_DEBUG_EN.
- Defined:
  - Adds register force[7:0] at DEBUG_ADDR, reset 8'h00.
  - Bus write sets force <= wdata.
  - Bus read returns deb | force.
  - The effective state used for n and irq is deb | force. This lets software and testbenches inject presses without the debounce delay.
- Undefined:
  - No force register exists.
  - DEBUG_ADDR reads 8'hFF and writes to it are ignored.
  - Effective state = deb.

Test Plan:
- Reset, then read FF00 with no buttons -> rdata 8'hFF; irq_joypad = 0.
- Write 8'h20 (select d-pad); hold buttons = 8'h01 (Right) steady -> after 2 + DEBOUNCE_CYCLES cycles, FF00 reads 8'hEE; irq_joypad pulses high exactly one cycle.
- Write 8'h10 (select buttons); hold buttons = 8'h10 (A); pulse Right for 2 cycles with DEBOUNCE_CYCLES = 4 -> no deb change from the Right pulse; FF00 reads 8'hDE after A settles; one irq only.
- Hold buttons = 8'h80 (Start) with sel = 11 (FF00 = 8'hFF); write 8'h10 -> next read 8'hD7; irq pulses once the cycle after the write. Write 8'h30 -> read 8'hFF, no irq.
- Hold buttons = 8'h05 with sel = 00 and deb settled; assert reset mid-press -> deb = 0, sel = 11, FF00 = 8'hFF, irq = 0. After release, input resettles -> a fresh irq only after re-select and full debounce.
- JOYPAD_DEBUG_EN: write force = 8'h08 with sel = 2'b10 -> FF00 reads 8'hE7 immediately the next cycle; irq pulses once; DEBUG_ADDR reads 8'h08.
